ysyx_24080014_regfile_sb: RTL and testbench
===========================================

# ysyx_24080014_regfile_sb

Parametrised integer register file with a load scoreboard and a machine-mode CSR bank for the ysyx_24080014 core. It replaces the fixed 32-entry GPR and flat CSR array with these features:
- configurable XLEN and register count (RV32I/RV32E);
- two combinational read ports with write-first bypass;
- separate ALU and late-load writeback ports;
- busy-bit stall generation for outstanding loads;
- architecturally correct ecall/mret handling of mstatus, plus a free-running 64-bit mcycle.

It sits between decode (reads, stall) and writeback/LSU (writes) in the single-issue pipeline.

## Interface
Parameters:
- XLEN, 32, data width of GPRs and CSRs
- NREG, 32, number of GPRs (32 = RV32I, 16 = RV32E); AW = $clog2(NREG)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- rs1_en, rs2_en  in  1  source operand used by the decoding instruction
- rs1_addr, rs2_addr  in  AW  source indices
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rd_en  in  1  decoding instruction writes a GPR
- rd_addr  in  AW  its destination index
- stall  out  1  decode must hold (combinational)
- wb_valid  in  1  ALU/CSR-result writeback strobe
- wb_rd  in  AW  ALU writeback index
- wb_data  in  XLEN  ALU writeback data
- ld_issue  in  1  load accepted by LSU this cycle; it marks rd_addr busy
- ld_wb_valid  in  1  load data return strobe
- ld_wb_rd  in  AW  load return index
- ld_wb_data  in  XLEN  load return data
- csr_addr  in  12  CSR index for read/write
- csr_rdata  out  XLEN  CSR read data (combinational)
- csr_we  in  1  CSR write strobe
- csr_wdata  in  XLEN  CSR write data (final value, after RS/RC)
- ecall, mret  in  1  trap/return strobes (qualified by commit)
- pc  in  XLEN  PC of the instruction raising ecall
- redirect_valid  out  1  ecall | mret
- redirect_pc  out  XLEN  trap target

## Operation
- GPRs: x0 reads 0 always; writes to x0 are dropped and never set busy.
- Write priority per index: ld_wb over wb when both target the same rd in the same cycle. This case is illegal upstream; the load value is stored.
- Bypass, applied per read port:
  - If ld_wb_valid and ld_wb_rd matches the port index, the port returns ld_wb_data.
  - Else if wb_valid and wb_rd matches, the port returns wb_data.
  - Else the port returns the register value.
- Scoreboard: busy[NREG-1:0].
  - ld_issue && rd_addr!=0 sets busy[rd_addr].
  - ld_wb_valid clears busy[ld_wb_rd].
  - If the same index is set and cleared in the same cycle, set wins: a new load is outstanding.
- stall = (rs1_en & busy[rs1_addr] & !ld_hit1) | (rs2_en & busy[rs2_addr] & !ld_hit2) | (rd_en & busy[rd_addr] & !ld_hit_rd).
  - ld_hit* means that index is being returned by ld_wb this cycle.
  - This covers RAW and WAW hazards.
- CSRs:
  - Implemented: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, mcycleh 0xB80.
  - Any other address reads 0; writes to it are ignored.
- mcycle: 64-bit counter, increments every cycle.
  - A csr_we to 0xB00 or 0xB80 replaces that half instead of incrementing that cycle.
  - Carry into the untouched half still applies.
  - It wraps from 2^64-1 to 0.
- ecall:
  - mepc <= pc; mcause <= 11.
  - mstatus.MPIE(7) <= MIE(3); MIE <= 0; MPP(12:11) <= 2'b11.
  - redirect_pc = mtvec.
- mret:
  - MIE <= MPIE; MPIE <= 1; MPP stays 2'b11.
  - redirect_pc = mepc.
- Simultaneous events:
  - ecall and mret together: ecall wins.
  - ecall/mret together with csr_we: the trap update wins on the CSRs it touches. The csr_we is dropped entirely, because the instruction is squashed.
- When no redirect, redirect_pc = 0.

## Timing
- Reads (rs*_data, csr_rdata, stall, redirect_pc) are combinational from current state and same-cycle writeback inputs.
- All state updates occur at posedge clk. Write-to-architectural-visibility latency is 1 cycle; reads in the same cycle see the value via bypass.
- redirect_pc uses pre-update mtvec/mepc, so the same-cycle value is visible.
- On rst_n low (asynchronous, at any point, including with loads outstanding):
  - all GPRs = 0, busy = 0;
  - mstatus = 0x00001800, mtvec = mepc = mcause = 0, mcycle = 0.
- Outputs during reset: stall=0, redirect_valid=0, rs*_data=0 unless bypassed.
- Outstanding loads are forgotten on reset; LSU returns after reset are written but clear nothing.

## Test plan
- Reset, then wb x5=0x1234 and read x5 in the same cycle -> rs1_data=0x1234 in that cycle. Read x0 after writing x0=0xFFFF -> 0.
- ld_issue rd=7; next cycle rs2_en rs2=7 -> stall=1. Cycle with ld_wb_valid rd=7 data=0xAB -> stall=0, rs2_data=0xAB. Following cycle busy[7]=0.
- ld_issue rd=3 in the same cycle as ld_wb rd=3 -> busy[3] stays 1, and a decode of rd_en rd=3 stalls next cycle.
- Write mtvec=0x80000100, mstatus MIE=1, then ecall pc=0x80000040:
  - same cycle: redirect_pc=0x80000100;
  - next cycle: mepc=0x80000040, mcause=11, mstatus=0x00001880.
  - Then mret -> redirect_pc=0x80000040; mstatus=0x00001888.
- mcycle: write 0xB00=0xFFFFFFFF with mcycleh=0 -> two cycles later mcycle=0x1_00000000. Read 0x7C0 -> 0.
- ecall with csr_we 0x341=0x5 in the same cycle -> mepc=pc, not 5. Assert rst_n low mid-load -> busy cleared asynchronously, stall=0 immediately.

Source files
------------

// File: rtl/ysyx_24080014_regfile_sb_if.sv
// Decode/writeback/CSR bus between the pipeline and the register file with scoreboard.
// The slave side is the register file; the master side is the pipeline (or a testbench).
interface ysyx_24080014_regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   localparam int AW = $clog2(NREG);

   logic            rs1_en;
   logic            rs2_en;
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic            stall;

   logic            wb_valid;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ld_issue;
   logic            ld_wb_valid;
   logic [AW-1:0]   ld_wb_rd;
   logic [XLEN-1:0] ld_wb_data;

   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_we;
   logic [XLEN-1:0] csr_wdata;
   logic            ecall;
   logic            mret;
   logic [XLEN-1:0] pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport slave (
      input  rs1_en, rs2_en, rs1_addr, rs2_addr, rd_en, rd_addr,
      input  wb_valid, wb_rd, wb_data, ld_issue, ld_wb_valid, ld_wb_rd, ld_wb_data,
      input  csr_addr, csr_we, csr_wdata, ecall, mret, pc,
      output rs1_data, rs2_data, stall, csr_rdata, redirect_valid, redirect_pc
   );

   modport master (
      output rs1_en, rs2_en, rs1_addr, rs2_addr, rd_en, rd_addr,
      output wb_valid, wb_rd, wb_data, ld_issue, ld_wb_valid, ld_wb_rd, ld_wb_data,
      output csr_addr, csr_we, csr_wdata, ecall, mret, pc,
      input  rs1_data, rs2_data, stall, csr_rdata, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/ysyx_24080014_regfile_sb.sv
// GPR file with write-first bypass, load busy-bit scoreboard and machine-mode CSR bank.
// XLEN must be at least 32; mcycle is always 64 bits, split into mcycle/mcycleh.
module ysyx_24080014_regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   ysyx_24080014_regfile_sb_if.slave bus
);
   localparam int AW = $clog2(NREG);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

   logic [XLEN-1:0] gpr [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;

   // mstatus is WARL: only MIE/MPIE are stored, MPP is hardwired to machine mode.
   logic            mie;
   logic            mpie;
   logic [XLEN-1:0] mstatus_val;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic [63:0]     mcycle;
   logic [63:0]     mcycle_next;

   logic            trap;
   logic            csr_wr;
   logic            ld_hit1;
   logic            ld_hit2;
   logic            ld_hit_rd;

   // ---------------- GPR read ports with bypass ----------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      bus.rs1_data = gpr[bus.rs1_addr];
      if (bus.rs1_addr == '0)
         bus.rs1_data = '0;
      else if (bus.ld_wb_valid && bus.ld_wb_rd == bus.rs1_addr)
         bus.rs1_data = bus.ld_wb_data;
      else if (bus.wb_valid && bus.wb_rd == bus.rs1_addr)
         bus.rs1_data = bus.wb_data;
   end

   always_comb begin
      bus.rs2_data = gpr[bus.rs2_addr];
      if (bus.rs2_addr == '0)
         bus.rs2_data = '0;
      else if (bus.ld_wb_valid && bus.ld_wb_rd == bus.rs2_addr)
         bus.rs2_data = bus.ld_wb_data;
      else if (bus.wb_valid && bus.wb_rd == bus.rs2_addr)
         bus.rs2_data = bus.wb_data;
   end

   // ---------------- GPR write ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the GPR array is architecturally reset, so it cannot map onto a RAM macro.
         for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            if (bus.ld_wb_valid && bus.ld_wb_rd == AW'(i))
               gpr[i] <= bus.ld_wb_data;
            else if (bus.wb_valid && bus.wb_rd == AW'(i))
               gpr[i] <= bus.wb_data;
         end
      end
   end

   // ---------------- Load scoreboard ----------------
   always_comb begin
      busy_next = busy;
      for (int i = 1; i < NREG; i++) begin
         if (bus.ld_issue && bus.rd_addr == AW'(i))
            busy_next[i] = 1'b1;
         else if (bus.ld_wb_valid && bus.ld_wb_rd == AW'(i))
            busy_next[i] = 1'b0;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_next;
   end

   assign ld_hit1   = bus.ld_wb_valid && (bus.ld_wb_rd == bus.rs1_addr);
   assign ld_hit2   = bus.ld_wb_valid && (bus.ld_wb_rd == bus.rs2_addr);
   assign ld_hit_rd = bus.ld_wb_valid && (bus.ld_wb_rd == bus.rd_addr);

   assign bus.stall = (bus.rs1_en && busy[bus.rs1_addr] && !ld_hit1)
                    | (bus.rs2_en && busy[bus.rs2_addr] && !ld_hit2)
                    | (bus.rd_en  && busy[bus.rd_addr]  && !ld_hit_rd);

   // ---------------- CSR bank ----------------
   assign trap   = bus.ecall | bus.mret;
   assign csr_wr = bus.csr_we & ~trap;

   always_comb begin
      mstatus_val        = '0;
      mstatus_val[12:11] = 2'b11;
      mstatus_val[7]     = mpie;
      mstatus_val[3]     = mie;
   end

   always_comb begin
      case (bus.csr_addr)
         CSR_MSTATUS: bus.csr_rdata = mstatus_val;
         CSR_MTVEC:   bus.csr_rdata = mtvec;
         CSR_MEPC:    bus.csr_rdata = mepc;
         CSR_MCAUSE:  bus.csr_rdata = mcause;
         CSR_MCYCLE:  bus.csr_rdata = XLEN'(mcycle[31:0]);
         CSR_MCYCLEH: bus.csr_rdata = XLEN'(mcycle[63:32]);
         default:     bus.csr_rdata = '0;
      endcase
   end

   // A written half takes the new value; the other half still sees the carry of the increment.
   always_comb begin
      mcycle_next = mcycle + 64'd1;
      if (csr_wr && bus.csr_addr == CSR_MCYCLE)
         mcycle_next[31:0] = bus.csr_wdata[31:0];
      if (csr_wr && bus.csr_addr == CSR_MCYCLEH)
         mcycle_next[63:32] = bus.csr_wdata[31:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie    <= 1'b0;
         mpie   <= 1'b0;
         mtvec  <= '0;
         mepc   <= '0;
         mcause <= '0;
         mcycle <= '0;
      end else begin
         mcycle <= mcycle_next;
         if (bus.ecall) begin
            mepc   <= bus.pc;
            mcause <= XLEN'(11);
            mpie   <= mie;
            mie    <= 1'b0;
         end else if (bus.mret) begin
            mie    <= mpie;
            mpie   <= 1'b1;
         end else if (csr_wr) begin
            case (bus.csr_addr)
               CSR_MSTATUS: begin
                  mie  <= bus.csr_wdata[3];
                  mpie <= bus.csr_wdata[7];
               end
               CSR_MTVEC:  mtvec  <= bus.csr_wdata;
               CSR_MEPC:   mepc   <= bus.csr_wdata;
               CSR_MCAUSE: mcause <= bus.csr_wdata;
               default: ;
            endcase
         end
      end
   end

   // Trap targets come from pre-update CSR state; nothing redirects while in reset.
   assign bus.redirect_valid = rst_n & trap;
   assign bus.redirect_pc    = !rst_n    ? '0
                             : bus.ecall ? mtvec
                             : bus.mret  ? mepc
                             : '0;
endmodule

// File: tb/tb_ysyx_24080014_regfile_sb.sv
// Directed self-checking bench for ysyx_24080014_regfile_sb: bypass, scoreboard, CSR/trap, mcycle, reset.
module tb_ysyx_24080014_regfile_sb;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   ysyx_24080014_regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();

   ysyx_24080014_regfile_sb #(.XLEN(32), .NREG(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.rs1_en = 0; bus.rs2_en = 0; bus.rs1_addr = '0; bus.rs2_addr = '0;
      bus.rd_en = 0; bus.rd_addr = '0;
      bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.ld_issue = 0; bus.ld_wb_valid = 0; bus.ld_wb_rd = '0; bus.ld_wb_data = '0;
      bus.csr_addr = '0; bus.csr_we = 0; bus.csr_wdata = '0;
      bus.ecall = 0; bus.mret = 0; bus.pc = '0;
   endtask

   // Advance past one rising edge; inputs are then changed and sampled well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic csr_read(input logic [11:0] addr, input string tag, input logic [31:0] exp);
      bus.csr_addr = addr;
      #1;
      check(tag, 64'(bus.csr_rdata), 64'(exp));
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      bus.rs1_addr = 5;
      #2;
      check("rst_stall", 64'(bus.stall), 64'd0);
      check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
      check("rst_rs1_x5", 64'(bus.rs1_data), 64'd0);
      csr_read(12'h300, "rst_mstatus", 32'h0000_1800);
      csr_read(12'hB00, "rst_mcycle", 32'h0);
      #9 rst_n = 1'b1;
      tick();

      // Write-first bypass and x0 handling.
      bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'h1234;
      bus.rs1_en = 1; bus.rs1_addr = 5;
      #1 check("bypass_wb_x5", 64'(bus.rs1_data), 64'h1234);
      tick();
      bus.rs2_addr = 5;
      #1 check("stored_x5", 64'(bus.rs2_data), 64'h1234);
      bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hFFFF; bus.rs1_addr = 0;
      #1 check("x0_bypass", 64'(bus.rs1_data), 64'd0);
      tick();
      bus.rs1_addr = 0;
      #1 check("x0_stored", 64'(bus.rs1_data), 64'd0);

      // Load on x7: RAW stall, release on the return cycle, busy cleared afterwards.
      bus.ld_issue = 1; bus.rd_addr = 7;
      tick();
      bus.rs2_addr = 7;
      #1 check("ld7_no_en_no_stall", 64'(bus.stall), 64'd0);
      bus.rs2_en = 1;
      #1 check("ld7_raw_stall", 64'(bus.stall), 64'd1);
      tick();
      bus.rs2_en = 1; bus.rs2_addr = 7;
      bus.ld_wb_valid = 1; bus.ld_wb_rd = 7; bus.ld_wb_data = 32'hAB;
      #1 check("ld7_return_stall", 64'(bus.stall), 64'd0);
      check("ld7_return_data", 64'(bus.rs2_data), 64'hAB);
      tick();
      bus.rs2_en = 1; bus.rs2_addr = 7;
      #1 check("ld7_cleared_stall", 64'(bus.stall), 64'd0);
      check("ld7_stored", 64'(bus.rs2_data), 64'hAB);

      // Same-index ALU and load writeback: load wins for bypass and storage.
      bus.wb_valid = 1; bus.wb_rd = 9; bus.wb_data = 32'h11;
      bus.ld_wb_valid = 1; bus.ld_wb_rd = 9; bus.ld_wb_data = 32'h22;
      bus.rs1_addr = 9;
      #1 check("prio_bypass_x9", 64'(bus.rs1_data), 64'h22);
      tick();
      bus.rs1_addr = 9;
      #1 check("prio_stored_x9", 64'(bus.rs1_data), 64'h22);

      // Set beats clear on x3; WAW stall; load to x0 never marks busy.
      bus.ld_issue = 1; bus.rd_addr = 3;
      tick();
      bus.ld_issue = 1; bus.rd_addr = 3;
      bus.ld_wb_valid = 1; bus.ld_wb_rd = 3; bus.ld_wb_data = 32'h33;
      tick();
      bus.rd_en = 1; bus.rd_addr = 3;
      #1 check("ld3_set_wins_waw", 64'(bus.stall), 64'd1);
      bus.ld_wb_valid = 1; bus.ld_wb_rd = 3; bus.ld_wb_data = 32'h34;
      #1 check("ld3_hit_rd_release", 64'(bus.stall), 64'd0);
      tick();
      bus.ld_issue = 1; bus.rd_addr = 0;
      tick();
      bus.rd_en = 1; bus.rd_addr = 0; bus.rs1_en = 1; bus.rs1_addr = 0;
      #1 check("ld_x0_no_busy", 64'(bus.stall), 64'd0);

      // CSR setup, ecall, mret.
      bus.csr_we = 1; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h8000_0100;
      tick();
      bus.csr_we = 1; bus.csr_addr = 12'h300; bus.csr_wdata = 32'h0000_1808;
      tick();
      csr_read(12'h300, "mstatus_mie_set", 32'h0000_1808);
      csr_read(12'h305, "mtvec_written", 32'h8000_0100);
      bus.csr_addr = '0;
      bus.ecall = 1; bus.pc = 32'h8000_0040;
      #1 check("ecall_redirect_valid", 64'(bus.redirect_valid), 64'd1);
      check("ecall_redirect_pc", 64'(bus.redirect_pc), 64'h8000_0100);
      tick();
      #1 check("no_trap_redirect_pc", 64'(bus.redirect_pc), 64'd0);
      check("no_trap_redirect_valid", 64'(bus.redirect_valid), 64'd0);
      csr_read(12'h341, "ecall_mepc", 32'h8000_0040);
      csr_read(12'h342, "ecall_mcause", 32'd11);
      csr_read(12'h300, "ecall_mstatus", 32'h0000_1880);
      bus.csr_addr = '0;
      bus.mret = 1;
      #1 check("mret_redirect_pc", 64'(bus.redirect_pc), 64'h8000_0040);
      tick();
      csr_read(12'h300, "mret_mstatus", 32'h0000_1888);

      // ecall + mret + csr_we in one cycle: ecall wins, CSR write squashed.
      bus.ecall = 1; bus.mret = 1; bus.pc = 32'h0000_0100;
      bus.csr_we = 1; bus.csr_addr = 12'h341; bus.csr_wdata = 32'h5;
      #1 check("ecall_mret_redirect_pc", 64'(bus.redirect_pc), 64'h8000_0100);
      tick();
      csr_read(12'h341, "squashed_csr_we_mepc", 32'h0000_0100);
      csr_read(12'h300, "ecall_over_mret_mstatus", 32'h0000_1880);

      // mcycle carry across halves; unimplemented CSR.
      bus.csr_we = 1; bus.csr_addr = 12'hB80; bus.csr_wdata = 32'h0;
      tick();
      bus.csr_we = 1; bus.csr_addr = 12'hB00; bus.csr_wdata = 32'hFFFF_FFFF;
      tick();
      csr_read(12'hB00, "mcycle_written_lo", 32'hFFFF_FFFF);
      tick();
      csr_read(12'hB00, "mcycle_wrap_lo", 32'h0);
      csr_read(12'hB80, "mcycle_carry_hi", 32'h1);
      bus.csr_we = 1; bus.csr_addr = 12'h7C0; bus.csr_wdata = 32'hDEAD;
      tick();
      csr_read(12'h7C0, "unimpl_csr_zero", 32'h0);

      // Asynchronous reset with a load outstanding.
      bus.ld_issue = 1; bus.rd_addr = 12;
      tick();
      bus.rs1_en = 1; bus.rs1_addr = 12;
      #1 check("ld12_stall_before_rst", 64'(bus.stall), 64'd1);
      rst_n = 1'b0;
      #1 check("async_rst_stall", 64'(bus.stall), 64'd0);
      bus.rs1_addr = 5;
      #1 check("async_rst_gpr", 64'(bus.rs1_data), 64'd0);
      csr_read(12'h300, "async_rst_mstatus", 32'h0000_1800);
      csr_read(12'h305, "async_rst_mtvec", 32'h0);
      #1 rst_n = 1'b1;
      tick();
      bus.rs1_en = 1; bus.rs1_addr = 12;
      #1 check("post_rst_no_stall", 64'(bus.stall), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
